// File: rtl/router_pkg.sv
// Shared flit layout and port encodings for the deflection router.
// Flit fields are addressed by LSB position so all blocks decode the same bits.
package router_pkg;
  localparam int FLIT_W   = 32;
  localparam int GOLD_BIT = 0;
  localparam int EJ_BIT   = 1;
  localparam int INP_LSB  = 2;
  localparam int OUTP_LSB = 4;
  localparam int SRC_LSB  = 7;
  localparam int DST_LSB  = 11;
  localparam int SEQ_LSB  = 15;
  localparam int LAST_LSB = 20;
  localparam int PAY_LSB  = 25;

  localparam logic [2:0] PORT_N     = 3'b000;
  localparam logic [2:0] PORT_E     = 3'b001;
  localparam logic [2:0] PORT_S     = 3'b010;
  localparam logic [2:0] PORT_W     = 3'b011;
  localparam logic [2:0] PORT_LOCAL = 3'b100;

  typedef enum logic {ST_IDLE, ST_SEND} dlv_state_e;
endpackage

// File: rtl/eject_reassembly_buffer_slot.sv
// One reassembly slot: flit storage, arrival bitmap, completion flag.
// Storage is unreset; only entries flagged in the bitmap are ever read out.
module reasm_slot
  import router_pkg::*;
#(
  parameter int MAX_FLITS = 8,
  localparam int IDX_W = $clog2(MAX_FLITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              valid,
  output logic [3:0]        src,
  output logic [4:0]        last_seq,
  output logic              complete,
  output logic [FLIT_W-1:0] rd_data
);
  logic [MAX_FLITS-1:0] bitmap, need;
  logic [FLIT_W-1:0]    mem [MAX_FLITS];

  always_comb begin
    need = '0;
    for (int i = 0; i < MAX_FLITS; i++) need[i] = (5'(i) <= last_seq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      src      <= '0;
      last_seq <= '0;
      bitmap   <= '0;
      complete <= 1'b0;
    end else if (clr) begin
      valid    <= 1'b0;
      bitmap   <= '0;
      complete <= 1'b0;
    end else begin
      if (alloc) begin
        valid    <= 1'b1;
        src      <= wr_data[SRC_LSB +: 4];
        last_seq <= wr_data[LAST_LSB +: 5];
      end
      if (wr_en) bitmap[wr_idx] <= 1'b1;
      // completion lags the bitmap by one edge
      complete <= valid && ((bitmap & need) == need);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/eject_reassembly_buffer.sv
// Local-port sink: reorders out-of-order ejected flits per source and
// streams each completed packet to the PE over valid/ready.
module eject_reassembly_buffer
  import router_pkg::*;
#(
  parameter logic [3:0] NODE_ID   = 4'h0,
  parameter int         NUM_SLOTS = 4,
  parameter int         MAX_FLITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ej_valid,
  input  logic [FLIT_W-1:0] ej_flit,
  output logic              eject_allow,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_last,
  input  logic              out_ready,
  output logic              drop_err
);
  localparam int IDX_W = $clog2(MAX_FLITS);
  localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [5:0] MAXF = 6'(MAX_FLITS);

  logic [3:0] f_src, f_dst;
  logic [4:0] f_seq, f_last;
  assign f_src  = ej_flit[SRC_LSB  +: 4];
  assign f_dst  = ej_flit[DST_LSB  +: 4];
  assign f_seq  = ej_flit[SEQ_LSB  +: 5];
  assign f_last = ej_flit[LAST_LSB +: 5];

  logic [NUM_SLOTS-1:0]             s_valid, s_complete, wr_vec, alloc_vec, clr_vec;
  logic [NUM_SLOTS-1:0][3:0]        s_src;
  logic [NUM_SLOTS-1:0][4:0]        s_last;
  logic [NUM_SLOTS-1:0][FLIT_W-1:0] s_rd;

  dlv_state_e       state, state_nx;
  logic [SEL_W-1:0] sel, sel_nx;
  logic [IDX_W-1:0] rd_ptr, rd_ptr_nx;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    reasm_slot #(.MAX_FLITS(MAX_FLITS)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .alloc    (alloc_vec[g]),
      .wr_en    (wr_vec[g]),
      .wr_idx   (f_seq[IDX_W-1:0]),
      .wr_data  (ej_flit),
      .clr      (clr_vec[g]),
      .rd_idx   (rd_ptr),
      .valid    (s_valid[g]),
      .src      (s_src[g]),
      .last_seq (s_last[g]),
      .complete (s_complete[g]),
      .rd_data  (s_rd[g])
    );
  end

  // match / allocate; the slot being streamed never matches so a new
  // packet from the same source lands in a fresh slot
  logic             hit, free_any, bad, drop;
  logic [SEL_W-1:0] hit_idx, free_idx, tgt;
  logic [4:0]       eff_last;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (s_valid[i] && s_src[i] == f_src && !(state == ST_SEND && sel == SEL_W'(i))) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
      if (!s_valid[i]) begin
        free_any = 1'b1;
        free_idx = SEL_W'(i);
      end
    end
    eff_last = hit ? s_last[hit_idx] : f_last;
    bad = (f_dst != NODE_ID) || ({1'b0, f_seq} >= MAXF) || ({1'b0, f_last} >= MAXF) ||
          (f_seq > eff_last) || (!hit && !free_any);
    drop = ej_valid && bad;
    tgt  = hit ? hit_idx : free_idx;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      wr_vec[i]    = ej_valid && !bad && (tgt == SEL_W'(i));
      alloc_vec[i] = ej_valid && !bad && !hit && (tgt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sel    <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nx;
      sel    <= sel_nx;
      rd_ptr <= rd_ptr_nx;
    end
  end

  logic             any_cmp;
  logic [SEL_W-1:0] cmp_idx;

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    rd_ptr_nx = rd_ptr;
    out_valid = 1'b0;
    out_flit  = '0;
    out_last  = 1'b0;
    clr_vec   = '0;
    any_cmp   = 1'b0;
    cmp_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (s_complete[i]) begin
        any_cmp = 1'b1;
        cmp_idx = SEL_W'(i);
      end
    end
    case (state)
      ST_IDLE: begin
        if (any_cmp) begin
          sel_nx    = cmp_idx;
          rd_ptr_nx = '0;
          state_nx  = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_flit  = s_rd[sel];
        out_last  = (rd_ptr == s_last[sel][IDX_W-1:0]);
        if (out_ready) begin
          rd_ptr_nx = rd_ptr + 1'b1;
          if (out_last) begin
            clr_vec[sel] = 1'b1;
            state_nx     = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // free-slot flag is registered from current occupancy, so a slot freed
  // at one edge shows up as free one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      eject_allow <= 1'b1;
      drop_err    <= 1'b0;
    end else begin
      eject_allow <= |(~s_valid);
      drop_err    <= drop;
    end
  end
endmodule

// File: tb/tb_eject_reassembly_buffer.sv
// Bench for eject_reassembly_buffer: directed scenarios with literal
// expectations plus random traffic checked each cycle against a packet-level model.
module tb_eject_reassembly_buffer;
  logic        clk = 0;
  logic        rst = 1;
  logic        ej_valid = 0;
  logic [31:0] ej_flit = 0;
  logic        eject_allow, out_valid, out_last, drop_err;
  logic [31:0] out_flit;
  logic        out_ready = 1;

  eject_reassembly_buffer #(.NODE_ID(4'h3), .NUM_SLOTS(4), .MAX_FLITS(8)) dut (
    .clk(clk), .rst(rst), .ej_valid(ej_valid), .ej_flit(ej_flit),
    .eject_allow(eject_allow), .out_valid(out_valid), .out_flit(out_flit),
    .out_last(out_last), .out_ready(out_ready), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mdl_ok = 0;
  bit          m_valid[4];
  int          m_src[4], m_last[4];
  bit [7:0]    m_bits[4];
  bit          m_cmp[4];
  int unsigned m_data[4][8];
  bit          m_busy;
  int          m_sel;
  int unsigned m_q[$];
  bit          m_allow, m_drop;

  function automatic int m_match(int src);
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_src[i] == src && !(m_busy && m_sel == i)) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit m_bad(logic [31:0] f);
    int s = int'(f[19:15]);
    int l = int'(f[24:20]);
    int mi = m_match(int'(f[10:7]));
    if (f[14:11] != 4'h3) return 1;
    if (s >= 8 || l >= 8) return 1;
    if (mi >= 0) return s > m_last[mi];
    if (m_free() < 0) return 1;
    return s > l;
  endfunction

  function automatic bit [7:0] needm(int l);
    return 8'((1 << (l + 1)) - 1);
  endfunction

  bit cmp_now[4];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 0; m_bits[i] = 0; m_cmp[i] = 0;
      end
      m_busy = 0; m_q.delete(); m_allow = 1; m_drop = 0; mdl_ok = 1;
    end else begin
      bit new_allow, bad, fire;
      int mi, s;
      fire = m_busy && out_ready;
      new_allow = 0;
      for (int i = 0; i < 4; i++) begin
        if (!m_valid[i]) new_allow = 1;
        cmp_now[i] = m_valid[i] && ((m_bits[i] & needm(m_last[i])) == needm(m_last[i]));
      end
      bad = ej_valid && m_bad(ej_flit);
      if (ej_valid && !bad) begin
        s  = int'(ej_flit[19:15]);
        mi = m_match(int'(ej_flit[10:7]));
        if (mi < 0) begin
          mi = m_free();
          m_valid[mi] = 1; m_src[mi] = int'(ej_flit[10:7]);
          m_last[mi] = int'(ej_flit[24:20]); m_bits[mi] = 0;
        end
        m_data[mi][s] = ej_flit;
        m_bits[mi][s] = 1;
      end
      if (m_busy) begin
        if (fire) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_valid[m_sel] = 0; m_bits[m_sel] = 0; cmp_now[m_sel] = 0; m_busy = 0;
          end
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (m_cmp[i] && !m_busy) begin
            m_busy = 1; m_sel = i;
            for (int k = 0; k <= m_last[i]; k++) m_q.push_back(m_data[i][k]);
          end
        end
      end
      for (int i = 0; i < 4; i++) m_cmp[i] = cmp_now[i];
      m_allow = new_allow;
      m_drop  = bad;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (mdl_ok) begin
      logic [31:0] ef;
      ef = 0;
      if (m_busy) ef = m_q[0];
      chk("out_valid", 32'(out_valid), 32'(m_busy));
      chk("out_flit", out_flit, ef);
      chk("out_last", 32'(out_last), 32'(m_busy && m_q.size() == 1));
      chk("eject_allow", 32'(eject_allow), 32'(m_allow));
      chk("drop_err", 32'(drop_err), 32'(m_drop));
    end
  end

  // delivered-flit collector for the directed checks
  logic [31:0] got[$];
  always @(negedge clk) if (!rst && out_valid && out_ready) got.push_back(out_flit);

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] f);
    ej_valid = 1; ej_flit = f; tick(); ej_valid = 0; ej_flit = 0;
  endtask

  task automatic do_reset();
    rst = 1; ej_valid = 0; out_ready = 1; tick(); tick(); rst = 0; got.delete();
  endtask

  task automatic chk_got(input string nm, input int n, input logic [31:0] a, b, c);
    logic [31:0] e[3];
    e[0] = a; e[1] = b; e[2] = c;
    chk({nm, " count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk({nm, " flit"}, got[i], e[i]);
  endtask

  function automatic logic [31:0] mk(int src, int dst, int seq, int last, int pay, int low);
    return {7'(pay), 5'(last), 5'(seq), 4'(dst), 4'(src), 7'(low)};
  endfunction

  localparam logic [31:0] A = 32'h00201900, B = 32'h00209900, C = 32'h00211900;

  // random-traffic generator state
  int gen_last[6], gen_pos[6], gen_ord[6][8];
  bit gen_active[6];

  function automatic bit src_in_model(int s);
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_src[i] == s) return 1;
    return 0;
  endfunction

  initial begin
    // reset state
    rst = 1; tick(); tick();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_flit", out_flit, 0);
    chk("rst out_last", 32'(out_last), 0);
    chk("rst drop_err", 32'(drop_err), 0);
    chk("rst eject_allow", 32'(eject_allow), 1);
    rst = 0; got.delete();

    // in-order packet and its latency
    send(A); send(B); send(C);
    chk("t1 lat+0", 32'(out_valid), 0);
    tick(); chk("t1 lat+1", 32'(out_valid), 0);
    tick(); chk("t1 lat+2", 32'(out_valid), 1); chk("t1 first", out_flit, A);
    repeat (8) tick();
    chk_got("t1", 3, A, B, C);

    // out-of-order arrival
    do_reset();
    send(C); send(A); send(B);
    repeat (10) tick();
    chk_got("t2", 3, A, B, C);

    // wrong destination
    do_reset();
    send(32'h00202100);
    chk("t3 drop_err", 32'(drop_err), 1);
    chk("t3 allow", 32'(eject_allow), 1);
    tick(); chk("t3 drop_err off", 32'(drop_err), 0);

    // slot exhaustion
    do_reset();
    for (int s = 0; s < 4; s++) send(mk(s, 3, 1, 1, 0, 0));
    tick(); chk("t4 allow full", 32'(eject_allow), 0);
    send(mk(5, 3, 0, 1, 0, 0));
    chk("t4 drop src5", 32'(drop_err), 1);
    send(mk(0, 3, 0, 1, 0, 0));
    repeat (8) tick();
    chk("t4 allow back", 32'(eject_allow), 1);
    chk_got("t4", 2, mk(0, 3, 0, 1, 0, 0), mk(0, 3, 1, 1, 0, 0), 0);

    // backpressure mid-packet
    do_reset();
    send(A); send(B); send(C);
    tick(); tick(); tick();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5 hold valid", 32'(out_valid), 1);
      chk("t5 hold flit", out_flit, B);
    end
    out_ready = 1;
    repeat (8) tick();
    chk_got("t5", 3, A, B, C);

    // reset during second flit
    do_reset();
    send(A); send(B); send(C);
    tick(); tick(); tick();
    rst = 1; tick();
    chk("t6 valid after rst", 32'(out_valid), 0);
    chk("t6 allow after rst", 32'(eject_allow), 1);
    rst = 0; got.delete();
    send(A); send(B); send(C);
    repeat (8) tick();
    chk_got("t6", 3, A, B, C);

    // randomized traffic
    do_reset();
    for (int s = 0; s < 6; s++) gen_active[s] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      ej_valid = 0; ej_flit = 0;
      if ($urandom_range(0, 2) != 0) begin
        int s, r, seq, last;
        logic [31:0] f;
        bit normal;
        s = $urandom_range(0, 5);
        r = $urandom_range(0, 19);
        normal = 0;
        if (!gen_active[s] && !src_in_model(s)) begin
          gen_last[s] = $urandom_range(0, 7);
          for (int k = 0; k < 8; k++) gen_ord[s][k] = k;
          for (int k = gen_last[s]; k > 0; k--) begin
            int j, t;
            j = $urandom_range(0, k);
            t = gen_ord[s][k]; gen_ord[s][k] = gen_ord[s][j]; gen_ord[s][j] = t;
          end
          gen_pos[s] = 0; gen_active[s] = 1;
        end
        last = gen_last[s];
        seq  = gen_ord[s][gen_pos[s]];
        if (r == 0)
          f = mk(s, (3 + $urandom_range(1, 15)) % 16, seq, last, $urandom, $urandom);
        else if (r == 1)
          f = mk(s, 3, $urandom_range(8, 31), last, $urandom, $urandom);
        else if (r == 4)
          f = mk(s, 3, seq, $urandom_range(8, 31), $urandom, $urandom);
        else if (!gen_active[s])
          f = mk(s, 4, 0, 0, $urandom, $urandom);
        else if (r == 2 && gen_pos[s] > 0)
          f = mk(s, 3, gen_ord[s][$urandom_range(0, gen_pos[s] - 1)], last, $urandom, $urandom);
        else if (r == 3 && last < 7)
          f = mk(s, 3, last + 1, last, $urandom, $urandom);
        else begin
          f = mk(s, 3, seq, last, $urandom, $urandom);
          normal = 1;
        end
        if (normal && !(m_match(s) < 0 && m_free() < 0)) begin
          gen_pos[s]++;
          if (gen_pos[s] > gen_last[s]) gen_active[s] = 0;
        end
        ej_valid = 1; ej_flit = f;
      end
      tick();
    end
    ej_valid = 0; ej_flit = 0; out_ready = 1;
    repeat (200) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
